stack_register_file: RTL

STACK_REGISTER_FILE -- requirements
Module: stack_register_file

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/sp_unit.sv | 65 ++++++
 rtl/stack_register_file.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the stack register file.
// Holds the default parameter values and the stack-pointer operation encoding.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 3;
    localparam int SP_INDEX_DEF = 2;
    localparam int SP_RESET_DEF = 256;
    localparam int SP_LIMIT_DEF = 0;
    localparam int SP_STEP_DEF  = 1;
    localparam int BYPASS_DEF   = 1;
    localparam int ZERO_REG_DEF = 0;
    localparam int REG_COUNT    = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        SP_HOLD = 2'd0,
        SP_PUSH = 2'd1,
        SP_POP  = 2'd2
    } spOp_t;

endpackage

// File: rtl/sp_unit.sv
// Stack-pointer next-value and fault computation.
// A register-file write to SP suppresses push/pop, so no fault can come from that cycle.
module sp_unit
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SP_RESET = SP_RESET_DEF,
    parameter int SP_LIMIT = SP_LIMIT_DEF,
    parameter int SP_STEP  = SP_STEP_DEF
) (
    input  logic [DATA_W-1:0] spCurrent,
    input  logic              spPush,
    input  logic              spPop,
    input  logic              writeHit,
    output logic [DATA_W-1:0] spNext,
    output logic              spFaultSet
);

    localparam logic [DATA_W:0] STEP_W  = (DATA_W+1)'(SP_STEP);
    localparam logic [DATA_W:0] LIMIT_W = (DATA_W+1)'(SP_LIMIT);
    localparam logic [DATA_W:0] RESET_W = (DATA_W+1)'(SP_RESET);

    logic [DATA_W:0] spWide;
    logic [DATA_W:0] popSum;
    logic [DATA_W:0] pushDiff;
    logic            underflow;
    logic            overflow;
    spOp_t           op;

    assign spWide    = {1'b0, spCurrent};
    assign popSum    = spWide + STEP_W;
    assign pushDiff  = spWide - STEP_W;
    // Checking spWide < STEP_W first keeps a wrapped difference from looking in range.
    assign underflow = (spWide < STEP_W) || (pushDiff < LIMIT_W);
    assign overflow  = popSum > RESET_W;

    always_comb begin
        op = SP_HOLD;
        if (!writeHit && spPush && !spPop) begin
            op = SP_PUSH;
        end else if (!writeHit && spPop && !spPush) begin
            op = SP_POP;
        end
    end

    always_comb begin
        spNext     = spCurrent;
        spFaultSet = 1'b0;
        case (op)
            SP_PUSH: begin
                if (underflow) spFaultSet = 1'b1;
                else           spNext     = pushDiff[DATA_W-1:0];
            end
            SP_POP: begin
                if (overflow) spFaultSet = 1'b1;
                else          spNext     = popSum[DATA_W-1:0];
            end
            default: begin
                spNext     = spCurrent;
                spFaultSet = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stack_register_file.sv
// Register file with a built-in stack pointer and registered dual read ports.
// With BYPASS set, reads see the value the register holds after the same edge.
module stack_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SP_INDEX = SP_INDEX_DEF,
    parameter int SP_RESET = SP_RESET_DEF,
    parameter int SP_LIMIT = SP_LIMIT_DEF,
    parameter int SP_STEP  = SP_STEP_DEF,
    parameter int BYPASS   = BYPASS_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0] writeFile,
    input  logic              regWrite,
    input  logic              spPush,
    input  logic              spPop,
    input  logic              spFaultClear,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] spValue,
    output logic              spFault
);

    localparam int                NUM_REGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR      = ADDR_W'(SP_INDEX);
    localparam logic [DATA_W-1:0] SP_RESET_VAL = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [DATA_W-1:0] regsNext [NUM_REGS];
    logic [DATA_W-1:0] spNext;
    logic [DATA_W-1:0] readSrc1;
    logic [DATA_W-1:0] readSrc2;
    logic              writeHit;
    logic              writeAllowed;
    logic              spFaultSet;

    assign writeHit     = regWrite && (writeReg == SP_ADDR);
    assign writeAllowed = regWrite && !((ZERO_REG != 0) && (writeReg == '0));
    assign spValue      = regs[SP_ADDR];

    sp_unit #(
        .DATA_W  (DATA_W),
        .SP_RESET(SP_RESET),
        .SP_LIMIT(SP_LIMIT),
        .SP_STEP (SP_STEP)
    ) u_spUnit (
        .spCurrent (regs[SP_ADDR]),
        .spPush    (spPush),
        .spPop     (spPop),
        .writeHit  (writeHit),
        .spNext    (spNext),
        .spFaultSet(spFaultSet)
    );

    always_comb begin
        regsNext          = regs;
        regsNext[SP_ADDR] = spNext;
        if (writeAllowed) begin
            regsNext[writeReg] = writeFile;
        end
    end

    always_comb begin
        readSrc1 = (BYPASS != 0) ? regsNext[readReg1] : regs[readReg1];
        readSrc2 = (BYPASS != 0) ? regsNext[readReg2] : regs[readReg2];
        if ((ZERO_REG != 0) && (readReg1 == '0)) readSrc1 = '0;
        if ((ZERO_REG != 0) && (readReg2 == '0)) readSrc2 = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET_VAL : '0;
            end
            readData1 <= '0;
            readData2 <= '0;
            spFault   <= 1'b0;
        end else begin
            regs      <= regsNext;
            readData1 <= readSrc1;
            readData2 <= readSrc2;
            // A fault on the same edge as a clear leaves the flag set.
            if (spFaultSet)        spFault <= 1'b1;
            else if (spFaultClear) spFault <= 1'b0;
        end
    end

endmodule
